// File: rtl/cpu_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_fsm
// Control FSM for the 16-bit RISC datapath. It sequences instruction fetch,
// decode and execute for MOV, ALU, LDR, STR and HALT, and drives the datapath,
// PC, IR and memory controls. Memory accesses use a ready handshake with an
// optional timeout. Faults are sticky until reset.
//
// Build option:
//   CTRL_BRANCH_EN  when defined, enables B/BEQ/BNE/BLT/BLE (001/00), BL (010/11)
//                   and BX (010/00). When undefined, opcodes 001/010 are illegal
//                   and pc_sel stays 00.
//
// Parameters:
//   MEM_TIMEOUT  maximum number of wait cycles per memory access (0 = no limit)
//   HALT_PC_RST  1: HALT pulses reset_pc/load_pc once before parking
//
// Ports:
//   clk, reset                   clock and synchronous active-high reset
//   opcode, op, cond             IR[15:13], IR[12:11], IR[10:8]
//   N, V, Z                      status flags
//   mem_ready                    memory completes the current access
//   nsel, vsel                   register-file read select and write-back source
//   write, loada, loadb, loadc, loads, asel, bsel    datapath controls
//   reset_pc, load_pc, load_ir, load_addr, addr_sel  PC/IR/address controls
//   pc_sel                       00 PC+1, 01 PC+1+sximm8, 10 datapath C
//   mem_cmd                      00 MREAD, 01 MNONE, 10 MWRITE
//   halted                       high while parked in HALT
//   fault                        00 none, 01 illegal instruction, 10 memory timeout
// ---------------------------------------------------------------------------
module cpu_ctrl_fsm #(
   parameter int MEM_TIMEOUT = 16,
   parameter bit HALT_PC_RST = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] opcode,
   input  logic [1:0] op,
   input  logic [2:0] cond,
   input  logic       N,
   input  logic       V,
   input  logic       Z,
   input  logic       mem_ready,
   output logic [1:0] nsel,
   output logic [1:0] vsel,
   output logic       write,
   output logic       loada,
   output logic       loadb,
   output logic       loadc,
   output logic       loads,
   output logic       asel,
   output logic       bsel,
   output logic       reset_pc,
   output logic       load_pc,
   output logic       load_ir,
   output logic       load_addr,
   output logic       addr_sel,
   output logic [1:0] pc_sel,
   output logic [1:0] mem_cmd,
   output logic       halted,
   output logic [1:0] fault
);

   localparam logic [1:0] MREAD  = 2'b00;
   localparam logic [1:0] MNONE  = 2'b01;
   localparam logic [1:0] MWRITE = 2'b10;

   localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LIM = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

   typedef enum logic [5:0] {
      S_RST, S_IF1, S_IF2, S_UPC, S_DEC,
      S_MOV_IMM, S_MV_B, S_MV_C, S_WR_RD,
      S_ALU_A, S_ALU_B, S_ALU_C,
      S_CMP_A, S_CMP_B, S_CMP_S,
      S_LDR_A, S_LDR_C, S_LDR_ADR, S_LDR_RD, S_LDR_WB,
      S_STR_A, S_STR_C, S_STR_ADR, S_STR_B, S_STR_C2, S_STR_WR,
      S_HALT_PC, S_HALT, S_FAULT,
      S_BL_W, S_BR_TAKE, S_BX_B, S_BX_C, S_BX_PC
   } state_t;

   state_t          state, next_state;
   logic [CW-1:0]   wait_cnt;
   logic [1:0]      flt_code;
   logic            wait_st;
   logic            timeout;

   // Memory-wait states hold their command until mem_ready; the counter
   // tracks how long the current access has been stalled.
   assign wait_st = (state == S_IF2) || (state == S_LDR_RD) || (state == S_STR_WR);
   assign timeout = (MEM_TIMEOUT != 0) && (wait_cnt == CNT_LIM);

`ifdef CTRL_BRANCH_EN
   logic br_take;
   always_comb begin
      br_take = 1'b0;
      case (cond)
         3'b000:  br_take = 1'b1;
         3'b001:  br_take = Z;
         3'b010:  br_take = !Z;
         3'b011:  br_take = (N != V);
         3'b100:  br_take = (N != V) || Z;
         default: br_take = 1'b0;
      endcase
   end
`else
   logic unused_branch_inputs;
   assign unused_branch_inputs = ^{cond, N, V, Z};
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_RST;
         wait_cnt <= '0;
         fault    <= 2'b00;
      end else begin
         state <= next_state;
         if (wait_st && !mem_ready && (next_state == state))
            wait_cnt <= wait_cnt + 1'b1;
         else
            wait_cnt <= '0;
         if ((next_state == S_FAULT) && (state != S_FAULT))
            fault <= flt_code;
      end
   end

   always_comb begin
      next_state = state;
      flt_code   = 2'b01;
      case (state)
         S_RST:     next_state = S_IF1;
         S_IF1:     next_state = S_IF2;
         S_IF2: begin
            // A ready arriving on the limit cycle completes the access.
            if (mem_ready)    next_state = S_UPC;
            else if (timeout) begin next_state = S_FAULT; flt_code = 2'b10; end
         end
         S_UPC:     next_state = S_DEC;
         S_DEC: begin
            casez ({opcode, op})
               5'b110_10: next_state = S_MOV_IMM;
               5'b110_00: next_state = S_MV_B;
               5'b101_00,
               5'b101_10: next_state = S_ALU_A;
               5'b101_01: next_state = S_CMP_A;
               5'b101_11: next_state = S_MV_B;
               5'b011_00: next_state = S_LDR_A;
               5'b100_00: next_state = S_STR_A;
               5'b111_??: next_state = HALT_PC_RST ? S_HALT_PC : S_HALT;
`ifdef CTRL_BRANCH_EN
               5'b001_00: begin
                  if (cond > 3'b100) next_state = S_FAULT;
                  else               next_state = br_take ? S_BR_TAKE : S_IF1;
               end
               5'b010_11: next_state = S_BL_W;
               5'b010_00: next_state = S_BX_B;
`endif
               default:   next_state = S_FAULT;
            endcase
         end
         S_MOV_IMM: next_state = S_IF1;
         S_MV_B:    next_state = S_MV_C;
         S_MV_C:    next_state = S_WR_RD;
         S_WR_RD:   next_state = S_IF1;
         S_ALU_A:   next_state = S_ALU_B;
         S_ALU_B:   next_state = S_ALU_C;
         S_ALU_C:   next_state = S_WR_RD;
         S_CMP_A:   next_state = S_CMP_B;
         S_CMP_B:   next_state = S_CMP_S;
         S_CMP_S:   next_state = S_IF1;
         S_LDR_A:   next_state = S_LDR_C;
         S_LDR_C:   next_state = S_LDR_ADR;
         S_LDR_ADR: next_state = S_LDR_RD;
         S_LDR_RD: begin
            if (mem_ready)    next_state = S_LDR_WB;
            else if (timeout) begin next_state = S_FAULT; flt_code = 2'b10; end
         end
         S_LDR_WB:  next_state = S_IF1;
         S_STR_A:   next_state = S_STR_C;
         S_STR_C:   next_state = S_STR_ADR;
         S_STR_ADR: next_state = S_STR_B;
         S_STR_B:   next_state = S_STR_C2;
         S_STR_C2:  next_state = S_STR_WR;
         S_STR_WR: begin
            if (mem_ready)    next_state = S_IF1;
            else if (timeout) begin next_state = S_FAULT; flt_code = 2'b10; end
         end
         S_HALT_PC: next_state = S_HALT;
         S_HALT:    next_state = S_HALT;
         S_FAULT:   next_state = S_FAULT;
`ifdef CTRL_BRANCH_EN
         S_BL_W:    next_state = S_BR_TAKE;
         S_BR_TAKE: next_state = S_IF1;
         S_BX_B:    next_state = S_BX_C;
         S_BX_C:    next_state = S_BX_PC;
         S_BX_PC:   next_state = S_IF1;
`endif
         default:   next_state = S_FAULT;
      endcase
   end

   // Moore output decode: every control is a function of the state alone.
   always_comb begin
      nsel = 2'b00;  vsel = 2'b00;
      write = 1'b0;  loada = 1'b0; loadb = 1'b0; loadc = 1'b0; loads = 1'b0;
      asel = 1'b0;   bsel = 1'b0;
      reset_pc = 1'b0; load_pc = 1'b0; load_ir = 1'b0; load_addr = 1'b0; addr_sel = 1'b0;
      pc_sel = 2'b00; mem_cmd = MNONE; halted = 1'b0;
      case (state)
         S_RST:     begin reset_pc = 1'b1; load_pc = 1'b1; asel = 1'b1; bsel = 1'b1; end
         S_IF1:     begin addr_sel = 1'b1; mem_cmd = MREAD; end
         S_IF2:     begin addr_sel = 1'b1; mem_cmd = MREAD; load_ir = 1'b1; end
         S_UPC:     load_pc = 1'b1;
         S_MOV_IMM: begin nsel = 2'b10; vsel = 2'b10; write = 1'b1; end
         S_MV_B, S_ALU_B, S_CMP_B: begin nsel = 2'b00; loadb = 1'b1; end
         S_MV_C, S_STR_C2, S_BX_C: begin asel = 1'b1; loadc = 1'b1; end
         S_WR_RD:   begin nsel = 2'b01; vsel = 2'b00; write = 1'b1; end
         S_ALU_A, S_CMP_A, S_LDR_A, S_STR_A: begin nsel = 2'b10; loada = 1'b1; end
         S_ALU_C:   loadc = 1'b1;
         S_CMP_S:   loads = 1'b1;
         S_LDR_C, S_STR_C: begin bsel = 1'b1; loadc = 1'b1; end
         S_LDR_ADR, S_STR_ADR: load_addr = 1'b1;
         S_LDR_RD:  mem_cmd = MREAD;
         S_LDR_WB:  begin nsel = 2'b01; vsel = 2'b11; write = 1'b1; end
         S_STR_B, S_BX_B: begin nsel = 2'b01; loadb = 1'b1; end
         S_STR_WR:  mem_cmd = MWRITE;
         S_HALT_PC: begin reset_pc = 1'b1; load_pc = 1'b1; end
         S_HALT:    halted = 1'b1;
`ifdef CTRL_BRANCH_EN
         S_BL_W:    begin nsel = 2'b10; vsel = 2'b01; write = 1'b1; end
         S_BR_TAKE: begin load_pc = 1'b1; pc_sel = 2'b01; end
         S_BX_PC:   begin load_pc = 1'b1; pc_sel = 2'b10; end
`endif
         default: ;
      endcase
   end

endmodule
